// File: rtl/cbadder_pkg.sv
// Shared definitions for the carry-bypass adder family and its serial inverse.
package cbadder_pkg;

    localparam int CB_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } inv_state_t;

endpackage

// File: rtl/fsub_bit.sv
// One-bit full subtractor: d = r - a - bin, with borrow-out.
module fsub_bit (
    input  logic r,
    input  logic a,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = r ^ a ^ bin;
    assign bout = (~r & a) | (~r & bin) | (a & bin);

endmodule

// File: rtl/cbadder_inverse_serial.sv
// Bit-serial inverse of the carry-bypass adder: recovers b = {cout,sum} - a - cin
// LSB first, one bit per clock, and flags results no adder input could produce.
module cbadder_inverse_serial
    import cbadder_pkg::*;
#(
    parameter int WIDTH = CB_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic             cin,
    input  logic [WIDTH-1:0] sum,
    input  logic             cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] b_out,
    output logic             err
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    inv_state_t       state;
    inv_state_t       state_nxt;
    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   a_sh;
    logic [WIDTH:0]   res;
    logic [WIDTH:0]   res_nxt;
    logic             borrow;
    logic [CNT_W-1:0] cnt;
    logic             last_bit;
    logic             d;
    logic             bout;

    fsub_bit u_fsub (
        .r    (r_sh[0]),
        .a    (a_sh[0]),
        .bin  (borrow),
        .d    (d),
        .bout (bout)
    );

    assign last_bit = (cnt == CNT_W'(WIDTH));
    assign res_nxt  = {d, res[WIDTH:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Operands are captured only on acceptance, so idle-time input garbage never enters state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh   <= '0;
            a_sh   <= '0;
            res    <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            b_out  <= '0;
            err    <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            r_sh   <= {cout, sum};
            a_sh   <= {1'b0, a};
            borrow <= cin;
            cnt    <= '0;
        end else if (state == RUN) begin
            res    <= res_nxt;
            r_sh   <= r_sh >> 1;
            a_sh   <= a_sh >> 1;
            borrow <= bout;
            cnt    <= cnt + 1'b1;
            if (last_bit) begin
                // A set top bit means the difference reached 2^WIDTH; a final borrow means it went negative.
                b_out <= res_nxt[WIDTH-1:0];
                err   <= d | bout;
            end
        end
    end

endmodule

// File: doc/cbadder_inverse_serial.md
Name: cbadder_inverse_serial

Overview:
- Bit-serial inverse of the 4-bit carry-bypass adder.
- Given an adder result {cout,sum} and the known operands a and cin, recovers operand b = {cout,sum} - a - cin, LSB first, one bit per clock.
- Sits beside the adder as a hardware self-check and round-trip consumer: adder outputs feed this block, and recovered b is compared against the original b.
- Also flags results that no adder input could have produced.

Parameters:
- WIDTH, 4, operand width. The result word {cout,sum} is WIDTH+1 bits.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request carries a valid adder result.
- in_ready  out  1  block can accept a request (high only in IDLE).
- a  in  WIDTH  adder operand a.
- cin  in  1  adder carry-in.
- sum  in  WIDTH  adder sum.
- cout  in  1  adder carry-out.
- out_valid  out  1  b_out and err are valid.
- out_ready  in  1  consumer accepts the result.
- b_out  out  WIDTH  recovered operand b.
- err  out  1  result is inconsistent: the true difference is negative or at least 2^WIDTH.

Behaviour:
- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, b_out=0, err=0, shift regs=0, borrow=0, bit counter=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge: latch R={cout,sum} and A={1'b0,a} into shift registers, set borrow=cin, counter=0, go to RUN.
  - in_valid without that edge has no effect.
- RUN:
  - in_ready=0.
  - Each edge processes bit i=counter: d = R[0] ^ A[0] ^ borrow; borrow' = (~R[0]&A[0]) | (~R[0]&borrow) | (A[0]&borrow).
  - d shifts into result register MSB-first fill, so bit i lands at position i after WIDTH+1 steps. R and A shift right.
  - counter increments. After the edge processing bit WIDTH, go to DONE.
  - RUN lasts exactly WIDTH+1 cycles.
- DONE:
  - out_valid=1.
  - b_out = result[WIDTH-1:0].
  - err = result[WIDTH] | final borrow. Negative difference: b_out is the low WIDTH bits of the two's-complement wrap.
  - Outputs held stable while out_ready=0, for any number of cycles.
  - On an edge with out_ready=1: go to IDLE, out_valid drops the next cycle.
- Latency: acceptance edge T0. out_valid rises after edge T0+WIDTH+1 (5 cycles at WIDTH=4).
- Throughput: at best one request per WIDTH+3 cycles. in_ready is low in RUN and DONE, so no overlap.
- Inputs a/cin/sum/cout are sampled only at acceptance. Later changes are ignored.
- b_out and err keep their last value outside DONE; only out_valid qualifies them.
- rst_n low in any state, including mid-RUN or DONE with out_ready=0, immediately returns all outputs to reset values. The partial result is discarded and no out_valid pulse occurs.
- X on inputs while in_valid=0 must not propagate into state.

Decomposition:
- Package cbadder_pkg:
  - localparam CB_WIDTH=4.
  - typedef enum logic [1:0] {IDLE, RUN, DONE} inv_state_t.
  - CB_WIDTH is shared with the adder and its bench.
- One sub-module: fsub_bit, a combinational 1-bit full subtractor (r, a, bin -> d, bout). Instantiated once and reused every cycle.

Test Plan:
- a=5, cin=1, sum=4'b1111, cout=0 -> after 5 cycles out_valid=1, b_out=9, err=0.
- a=15, cin=1, sum=4'b1111, cout=1 (31) -> b_out=15, err=0.
- a=5, cin=0, sum=4'b0010, cout=0 (2-5) -> err=1, b_out=4'b1101.
- a=0, cin=0, sum=0, cout=1 (16) -> err=1, b_out=0.
- out_ready held low 6 cycles in DONE, with a/sum toggled and in_valid=1 -> b_out, err and out_valid stable, in_ready=0, new request ignored. Release out_ready -> IDLE next cycle, in_ready=1.
- Closed loop with the cbadder model over all 16x16x2 (a,b,cin) -> every b_out==b, err=0. rst_n pulsed low at RUN cycle 2 of one request -> out_valid stays 0 and the next request completes correctly.
